reduce_serial: RTL



---
 rtl/reduce_pkg.sv | 26 ++
 rtl/reduce_chunk.sv | 27 ++
 rtl/reduce_serial.sv | 139 +++++++++++++
 3 files changed

// File: rtl/reduce_pkg.sv
// Shared definitions for the serial reducer: mode codes, FSM states, sizing and identity helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package reduce_pkg;

   localparam logic [1:0] MODE_AND  = 2'b00;
   localparam logic [1:0] MODE_OR   = 2'b01;
   localparam logic [1:0] MODE_XOR  = 2'b10;
   localparam logic [1:0] MODE_NAND = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   // DigitSupply index holding the mode's identity: rail 1 for AND/NAND, rail 0 for OR/XOR.
   function automatic logic identity_idx(input logic [1:0] mode);
      return (mode == MODE_AND) || (mode == MODE_NAND);
   endfunction

endpackage

// File: rtl/reduce_chunk.sv
// Combinational reduction of one CHUNK_WIDTH-bit slice by mode.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the parent FSM decides when the result is consumed.
// Ports: mode_i (2b mode code), chunk_i (slice to reduce), red_o (1b reduction).
module reduce_chunk
   import reduce_pkg::*;
#(
   parameter int CHUNK_WIDTH = 2
) (
   input  logic [1:0]             mode_i,
   input  logic [CHUNK_WIDTH-1:0] chunk_i,
   output logic                   red_o
);

   // NAND reduces as AND here; the inversion is applied once to the final result.
   always_comb begin
      red_o = 1'b0;
      case (mode_i)
         MODE_AND:  red_o = &chunk_i;
         MODE_OR:   red_o = |chunk_i;
         MODE_XOR:  red_o = ^chunk_i;
         MODE_NAND: red_o = &chunk_i;
         default:   red_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/reduce_serial.sv
// Serial AND/OR/XOR/NAND reducer: CHUNK_WIDTH bits per clock with valid/ready on both sides.
// Latency: outValid rises NUM_CHUNKS edges after accept (earlier with REDUCE_EARLY_EXIT_EN defined).
// Backpressure: result holds in DONE until outReady; a new operand is taken on the same handshake edge.
// Ports: Clock, Reset_n (async active-low), DigitSupply ([1]=logic-1, [0]=logic-0 rail),
//        inValid/inReady/inputData/Mode (operand side), outValid/outReady/outputData (result side),
//        Busy (high while reducing). Optional macro: REDUCE_EARLY_EXIT_EN.
module reduce_serial
   import reduce_pkg::*;
#(
   parameter int INPUT_WIDTH = 8,
   parameter int CHUNK_WIDTH = 2
) (
   input  logic                   Clock,
   input  logic                   Reset_n,
   input  logic [1:0]             DigitSupply,
   input  logic                   inValid,
   output logic                   inReady,
   input  logic [INPUT_WIDTH-1:0] inputData,
   input  logic [1:0]             Mode,
   output logic                   outValid,
   input  logic                   outReady,
   output logic                   outputData,
   output logic                   Busy
);

   localparam int NUM_CHUNKS = ceil_div(INPUT_WIDTH, CHUNK_WIDTH);
   localparam int SR_W       = NUM_CHUNKS * CHUNK_WIDTH;
   localparam int CNT_W      = $clog2(NUM_CHUNKS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);
   // Bits above the operand that form the padding of the last partial chunk.
   localparam logic [SR_W-1:0]  PAD_MASK = {SR_W{1'b1}} << INPUT_WIDTH;

   state_t            state_q;
   logic [SR_W-1:0]   shreg_q;
   logic [SR_W-1:0]   shreg_load;
   logic [1:0]        mode_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              acc_q;
   logic              acc_d;
   logic              out_valid_q;
   logic              out_data_q;
   logic              busy_q;
   logic              chunk_red;
   logic              accept;
   logic              last_chunk;
   logic              id_in;

   assign inReady = (state_q == ST_IDLE) || ((state_q == ST_DONE) && outReady);
   assign accept  = inValid && inReady;

   // Identity of the incoming mode, taken from the supply rails.
   assign id_in      = DigitSupply[identity_idx(Mode)];
   assign shreg_load = SR_W'(inputData) | (PAD_MASK & {SR_W{id_in}});

   reduce_chunk #(
      .CHUNK_WIDTH (CHUNK_WIDTH)
   ) u_chunk (
      .mode_i  (mode_q),
      .chunk_i (shreg_q[CHUNK_WIDTH-1:0]),
      .red_o   (chunk_red)
   );

   always_comb begin
      acc_d = acc_q;
      case (mode_q)
         MODE_AND:  acc_d = acc_q & chunk_red;
         MODE_OR:   acc_d = acc_q | chunk_red;
         MODE_XOR:  acc_d = acc_q ^ chunk_red;
         MODE_NAND: acc_d = acc_q & chunk_red;
         default:   acc_d = acc_q;
      endcase
   end

`ifdef REDUCE_EARLY_EXIT_EN
   // Once the accumulator holds the dominant value no later chunk can change it.
   logic dominant;
   always_comb begin
      dominant = 1'b0;
      case (mode_q)
         MODE_AND:  dominant = ~acc_d;
         MODE_NAND: dominant = ~acc_d;
         MODE_OR:   dominant = acc_d;
         default:   dominant = 1'b0;
      endcase
   end
   assign last_chunk = (cnt_q == LAST_CNT) || dominant;
`else
   assign last_chunk = (cnt_q == LAST_CNT);
`endif

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= ST_IDLE;
         shreg_q     <= '0;
         mode_q      <= MODE_AND;
         cnt_q       <= '0;
         acc_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else if (accept) begin
         // Taken from IDLE or straight out of DONE on the result handshake.
         state_q     <= ST_RUN;
         shreg_q     <= shreg_load;
         mode_q      <= Mode;
         cnt_q       <= '0;
         acc_q       <= id_in;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               acc_q   <= acc_d;
               shreg_q <= shreg_q >> CHUNK_WIDTH;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (last_chunk) begin
                  state_q     <= ST_DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
                  out_data_q  <= acc_d ^ (mode_q == MODE_NAND);
               end
            end
            ST_DONE: begin
               if (outReady) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            ST_IDLE: ;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign outValid   = out_valid_q;
   assign outputData = out_data_q;
   assign Busy       = busy_q;

endmodule
